// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide sequencer for the EX stage: fixed-latency multiply,
// 32-iteration restoring divide, and a stall toward pipeline control while busy.
module hilo_muldiv_ctrl #(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [5:0]  op_code,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data,
  output logic        div_by_zero
);

  localparam logic [5:0] OP_MFHI  = 6'd16;
  localparam logic [5:0] OP_MTHI  = 6'd17;
  localparam logic [5:0] OP_MFLO  = 6'd18;
  localparam logic [5:0] OP_MTLO  = 6'd19;
  localparam logic [5:0] OP_MULT  = 6'd24;
  localparam logic [5:0] OP_MULTU = 6'd25;
  localparam logic [5:0] OP_DIV   = 6'd26;
  localparam logic [5:0] OP_DIVU  = 6'd27;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t      state, state_next;
  logic [4:0]  cnt;
  logic [63:0] prod;
  logic [31:0] rem, quo, divisor;
  logic        neg_q, neg_r;

  logic        hilo_op, accept, is_mul, is_div;
  logic [63:0] prod_in;
  logic [31:0] a_mag, b_mag;
  logic [32:0] shifted, trial;
  logic [31:0] q_fix, r_fix;

  always_comb begin
    hilo_op = op_code inside {OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO,
                              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    stall   = op_valid & hilo_op & busy;
    accept  = op_valid & hilo_op & ~stall & ~flush;
    is_mul  = (op_code == OP_MULT) || (op_code == OP_MULTU);
    is_div  = (op_code == OP_DIV)  || (op_code == OP_DIVU);

    rd_data = '0;
    if (op_valid && op_code == OP_MFHI) rd_data = hi;
    if (op_valid && op_code == OP_MFLO) rd_data = lo;

    // Sign-extending to 64 bits makes the low 64 product bits the signed product
    if (op_code == OP_MULT)
      prod_in = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    else
      prod_in = {32'd0, src_a} * {32'd0, src_b};

    a_mag = (op_code == OP_DIV && src_a[31]) ? -src_a : src_a;
    b_mag = (op_code == OP_DIV && src_b[31]) ? -src_b : src_b;

    shifted = {rem, quo[31]};
    trial   = shifted - {1'b0, divisor};
    q_fix   = neg_q ? -quo : quo;
    r_fix   = neg_r ? -rem : rem;

    state_next = state;
    case (state)
      IDLE: if (accept) begin
        if (is_mul) state_next = MUL;
        else if (is_div && src_b != '0) state_next = DIV;
      end
      MUL:  if (cnt == 5'd0) state_next = IDLE;
      DIV:  if (cnt == 5'd0) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush && state != IDLE) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      prod        <= '0;
      rem         <= '0;
      quo         <= '0;
      divisor     <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      state       <= state_next;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (op_code == OP_MTHI) hi <= src_a;
          if (op_code == OP_MTLO) lo <= src_a;
          if (is_mul) begin
            prod <= prod_in;
            cnt  <= 5'(MUL_LAT - 1);
            busy <= 1'b1;
          end
          if (is_div) begin
            if (src_b == '0) begin
              lo          <= '1;
              hi          <= src_a;
              div_by_zero <= 1'b1;
            end else begin
              quo     <= a_mag;
              rem     <= '0;
              divisor <= b_mag;
              neg_q   <= (op_code == OP_DIV) && (src_a[31] ^ src_b[31]);
              neg_r   <= (op_code == OP_DIV) && src_a[31];
              cnt     <= 5'd31;
              busy    <= 1'b1;
            end
          end
        end
        MUL: begin
          if (flush) busy <= 1'b0;
          else if (cnt == 5'd0) begin
            {hi, lo} <= prod;
            busy     <= 1'b0;
          end else cnt <= cnt - 5'd1;
        end
        DIV: begin
          if (flush) busy <= 1'b0;
          else begin
            if (!trial[32]) begin
              rem <= trial[31:0];
              quo <= {quo[30:0], 1'b1};
            end else begin
              rem <= shifted[31:0];
              quo <= {quo[30:0], 1'b0};
            end
            if (cnt != 5'd0) cnt <= cnt - 5'd1;
          end
        end
        FIX: begin
          busy <= 1'b0;
          if (!flush) begin
            lo <= q_fix;
            hi <= r_fix;
          end
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed-vector bench for hilo_muldiv_ctrl with hand-computed HI/LO results.
module tb_hilo_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic [5:0]  op_code;
  logic [31:0] src_a, src_b;
  logic        flush;
  logic        stall, busy, div_by_zero;
  logic [31:0] hi, lo, rd_data;

  int vectors = 0;
  int errs    = 0;

  hilo_muldiv_ctrl #(.MUL_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
    .src_a(src_a), .src_b(src_b), .flush(flush), .stall(stall), .busy(busy),
    .hi(hi), .lo(lo), .rd_data(rd_data), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op_code  = op;
    src_a    = a;
    src_b    = b;
    #1;
  endtask

  task automatic idle_inputs();
    op_valid = 1'b0;
    op_code  = 6'd0;
    src_a    = 32'hDEAD_BEEF;
    src_b    = 32'h0BAD_F00D;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    flush = 1'b0;
    idle_inputs();
    #12;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    tick();

    // mult 7 * -3
    issue(6'd24, 32'd7, 32'hFFFF_FFFD);
    chk("mult_nostall", {31'd0, stall}, 32'd0);
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      chk("mult_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    chk("mult_busy_last", {31'd0, busy}, 32'd1);
    chk("mult_lo_early", lo, 32'h0);
    tick();
    chk("mult_done", {31'd0, busy}, 32'd0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);

    // multu FFFFFFFF * 2
    issue(6'd25, 32'hFFFF_FFFF, 32'd2);
    tick();
    idle_inputs();
    repeat (4) tick();
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // div -7 / 2
    issue(6'd26, 32'hFFFF_FFF9, 32'd2);
    tick();
    idle_inputs();
    repeat (32) tick();
    chk("div_busy32", {31'd0, busy}, 32'd1);
    tick();
    chk("div_done", {31'd0, busy}, 32'd0);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // divu FFFFFFF9 / 2
    issue(6'd27, 32'hFFFF_FFF9, 32'd2);
    tick();
    idle_inputs();
    repeat (33) tick();
    chk("divu_lo", lo, 32'h7FFF_FFFC);
    chk("divu_hi", hi, 32'h0000_0001);

    // signed overflow case
    issue(6'd26, 32'h8000_0000, 32'hFFFF_FFFF);
    tick();
    idle_inputs();
    repeat (33) tick();
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0);

    // mflo stalled behind divu 100 / 7
    issue(6'd27, 32'd100, 32'd7);
    tick();
    idle_inputs();
    repeat (4) tick();
    issue(6'd18, 32'd0, 32'd0);
    chk("mflo_stall", {31'd0, stall}, 32'd1);
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    chk("mflo_stall_cycles", n, 32'd29);
    chk("mflo_unstalled", {31'd0, stall}, 32'd0);
    chk("mflo_rd", rd_data, 32'h0000_000E);
    chk("divu7_hi", hi, 32'h0000_0002);
    tick();
    idle_inputs();

    // div 5 / 0
    issue(6'd26, 32'd5, 32'd0);
    chk("dz_nostall", {31'd0, stall}, 32'd0);
    tick();
    idle_inputs();
    chk("dz_lo", lo, 32'hFFFF_FFFF);
    chk("dz_hi", hi, 32'h0000_0005);
    chk("dz_pulse", {31'd0, div_by_zero}, 32'd1);
    chk("dz_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("dz_pulse_end", {31'd0, div_by_zero}, 32'd0);

    // mthi then mfhi
    issue(6'd17, 32'h1234_5678, 32'd0);
    tick();
    issue(6'd16, 32'd0, 32'd0);
    chk("mfhi_rd", rd_data, 32'h1234_5678);
    chk("mfhi_nostall", {31'd0, stall}, 32'd0);
    issue(6'd20, 32'd9, 32'd9);
    chk("other_rd", rd_data, 32'h0);
    tick();
    idle_inputs();
    chk("other_ignored", {31'd0, busy}, 32'd0);

    // op presented with flush is not accepted
    flush = 1'b1;
    issue(6'd17, 32'hAAAA_5555, 32'd0);
    tick();
    flush = 1'b0;
    idle_inputs();
    chk("flush_idle_hi", hi, 32'h1234_5678);

    // flush mid-divide, then mult accepted immediately
    issue(6'd26, 32'd100, 32'd7);
    tick();
    idle_inputs();
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_hi", hi, 32'h1234_5678);
    chk("flush_lo", lo, 32'hFFFF_FFFF);
    issue(6'd24, 32'd3, 32'd5);
    chk("post_flush_nostall", {31'd0, stall}, 32'd0);
    tick();
    idle_inputs();
    chk("post_flush_busy", {31'd0, busy}, 32'd1);
    repeat (4) tick();
    chk("post_flush_lo", lo, 32'd15);
    chk("post_flush_hi", hi, 32'd0);

    // async reset mid-multiply
    issue(6'd24, 32'd2, 32'd3);
    tick();
    idle_inputs();
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_lo", lo, 32'h0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("arst_lo_after", lo, 32'h0);
    chk("arst_hi_after", hi, 32'h0);
    chk("arst_busy_after", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
Multi-cycle sequencer that owns the HI/LO register pair and executes mult/multu/div/divu/mthi/mtlo/mfhi/mflo for the EX stage. It takes these ops off the single-cycle ALU path: multiply runs for a fixed latency, divide runs as a 32-iteration restoring divider. It raises stall toward the pipeline control whenever a HI/LO op arrives while an operation is in flight. Op codes use the ALU's alu_control encoding.

Parameters:
MUL_LAT, 4, cycles from multiply acceptance to HI/LO update; legal range 1..16.

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
op_valid  in  1  EX-stage op present this cycle
op_code  in  6  16 mfhi, 17 mthi, 18 mflo, 19 mtlo, 24 mult, 25 multu, 26 div, 27 divu; other values ignored
src_a  in  32  RS operand (dividend / multiplicand / mthi-mtlo data)
src_b  in  32  RT operand (divisor / multiplier)
flush  in  1  abort in-flight op (branch/exception squash)
stall  out  1  combinational; hold EX and upstream stages
busy  out  1  registered; multi-cycle op in flight
hi  out  32  HI register
lo  out  32  LO register
rd_data  out  32  combinational mfhi/mflo result; 0 for other ops
div_by_zero  out  1  one-cycle pulse on div/divu with src_b==0

Behaviour:
- Reset: state IDLE; hi, lo, busy, div_by_zero, counters and operand registers all 0. Asynchronous reset mid-operation discards all progress.
- HI/LO op = op_code in {16,17,18,19,24,25,26,27}.
- stall = op_valid & HI/LO op & busy. No other stall source.
- Accept = op_valid & HI/LO op & !stall & !flush.
- States: IDLE, MUL, DIV, FIX.
- IDLE, accepted op:
  - mthi/mtlo: write hi/lo at the same edge.
  - mfhi/mflo: rd_data = hi/lo in the same cycle; no stall.
  - mult/multu: latch the 64-bit product (signed or unsigned); counter = MUL_LAT-1; go to MUL.
  - div/divu with src_b != 0: latch magnitudes (signed) or raw values (unsigned) and the result signs; counter = 31; go to DIV.
  - div/divu with src_b == 0: completes in one cycle; lo = 32'hFFFFFFFF, hi = src_a; div_by_zero pulses next cycle; stay IDLE.
- MUL: busy=1; decrement counter; when counter==0, write {hi,lo} = product and go to IDLE. HI/LO update at edge T+MUL_LAT after acceptance at cycle T.
- DIV: busy=1; one restoring iteration per cycle (shift remainder/quotient, trial subtract, keep if non-negative). After the 32nd iteration go to FIX.
- FIX: busy=1; signed ops negate the quotient if operand signs differ and give the remainder the dividend's sign; write lo = quotient, hi = remainder; go to IDLE. Divide latency = 33 cycles (HI/LO valid after edge T+33).
- Overflow: -2^31 / -1 gives lo = 32'h80000000, hi = 0, with no flag.
- Busy is cleared at the same edge that writes HI/LO, so a stalled mfhi/mflo proceeds in the next cycle and reads the new value.
- flush: at the next edge, return to IDLE with busy=0; HI/LO unchanged. An op presented with flush high is not accepted. flush in IDLE has no effect.
- Operand registers are captured at acceptance; later changes on src_a/src_b while busy are ignored.

Test Plan:
- mult 7 × -3 (FFFFFFFD) with MUL_LAT=4 -> busy for 4 cycles; hi=FFFFFFFF, lo=FFFFFFEB after edge T+4. multu FFFFFFFF × 2 -> hi=00000001, lo=FFFFFFFE.
- div -7 / 2 -> after 33 cycles lo=FFFFFFFD, hi=FFFFFFFF. divu FFFFFFF9 / 2 -> lo=7FFFFFFC, hi=00000001. div 80000000 / FFFFFFFF -> lo=80000000, hi=0.
- mflo issued 5 cycles into a divide -> stall=1 until busy falls; first unstalled cycle rd_data equals the new lo; no extra bubble.
- div 5 / 0 -> no stall; lo=FFFFFFFF, hi=00000005; div_by_zero high exactly one cycle.
- mthi 12345678, then mfhi next cycle -> rd_data=12345678. flush at cycle 10 of a div -> busy=0 next cycle; hi/lo keep prior values; a following mult is accepted immediately.
- rst_n pulsed low mid-multiply -> hi=lo=0 and busy=0 immediately; no HI/LO write after release.
